// File: rtl/pma_pkg.sv
// rtl/pma_pkg.sv - shared types and helpers for the PMA transmit serializer
package pma_pkg;

    typedef enum logic {
        S_EIDLE  = 1'b0,
        S_ACTIVE = 1'b1
    } tx_state_t;

    // Widest supported symbol; reverse_bits works on words padded to this width.
    localparam int MAX_WIDTH = 40;

    // Ceiling log2, used to size the bit counter.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Mirror the low 'width' bits of a word so MSB-first symbols shift out LSB-first.
    function automatic logic [MAX_WIDTH-1:0] reverse_bits(input logic [MAX_WIDTH-1:0] word,
                                                         input int width);
        logic [MAX_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < width) begin
                r[i] = word[width-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pma_tx_shift_core.sv
// rtl/pma_tx_shift_core.sv - symbol bit counter and output shift register
module pma_tx_shift_core
    import pma_pkg::*;
#(
    parameter int DATA_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  active_i,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] load_word_i,
    output logic                  boundary_o,
    output logic                  serial_bit_o
);

    localparam int CW = clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shifter_q, shifter_d;

    assign boundary_o   = (bit_cnt_q == LAST_BIT);
    assign serial_bit_o = shifter_q[0];

    // Load restarts the symbol; while active, advance one bit per clock and wrap at the boundary.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shifter_d = shifter_q;
        if (load_i) begin
            bit_cnt_d = '0;
            shifter_d = load_word_i;
        end else if (active_i) begin
            bit_cnt_d = boundary_o ? '0 : bit_cnt_q + 1'b1;
            shifter_d = shifter_q >> 1;
        end else begin
            bit_cnt_d = '0;
        end
    end

    // Counter and shifter registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            bit_cnt_q <= '0;
            shifter_q <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shifter_q <= shifter_d;
        end
    end

endmodule

// File: rtl/pma_tx_serializer.sv
// rtl/pma_tx_serializer.sv - PMA transmit serializer top: FSM, hold register, handshake, output gating
module pma_tx_serializer
    import pma_pkg::*;
#(
    parameter int DATA_WIDTH = 10,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                  Bit_Rate_Clk,
    input  logic                  Rst_n,
    input  logic [DATA_WIDTH-1:0] Data_in,
    input  logic                  MAC_Data_En,
    output logic                  Data_Ready,
    input  logic [DATA_WIDTH-1:0] Idle_Sym,
    input  logic                  Tx_En,
    input  logic                  Polarity_Inv,
    output logic                  TX_Out_P,
    output logic                  TX_Out_N,
    output logic                  Sym_Strobe,
    output logic                  Underrun
);

    tx_state_t             state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_vld_q, hold_vld_d;
    logic                  strobe_q, underrun_q;

    logic                  active;
    logic                  boundary;
    logic                  serial_bit;
    logic                  load;
    logic                  data_write;
    logic [DATA_WIDTH-1:0] sel_word;
    logic [MAX_WIDTH-1:0]  rev_word;
    logic [DATA_WIDTH-1:0] load_word;
    logic                  line_bit;

    assign active = (state_q == S_ACTIVE);

    // A symbol is loaded on entry from idle or at each symbol boundary while transmit stays enabled.
    assign load       = Tx_En & ((state_q == S_EIDLE) | boundary);
    assign Data_Ready = Rst_n & (~hold_vld_q | load);
    assign data_write = MAC_Data_En & Data_Ready;

    // Underrun substitutes the idle symbol; MSB-first symbols are mirrored once here at load.
    assign sel_word  = hold_vld_q ? hold_q : Idle_Sym;
    assign rev_word  = reverse_bits(MAX_WIDTH'(sel_word), DATA_WIDTH);
    assign load_word = LSB_FIRST ? sel_word : rev_word[DATA_WIDTH-1:0];

    pma_tx_shift_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shift_core (
        .clk_i        (Bit_Rate_Clk),
        .rst_ni       (Rst_n),
        .active_i     (active),
        .load_i       (load),
        .load_word_i  (load_word),
        .boundary_o   (boundary),
        .serial_bit_o (serial_bit)
    );

    // Both legs are held low in electrical idle; otherwise a polarity-adjusted differential pair.
    assign line_bit   = serial_bit ^ Polarity_Inv;
    assign TX_Out_P   = active & line_bit;
    assign TX_Out_N   = active & ~line_bit;
    assign Sym_Strobe = strobe_q;
    assign Underrun   = underrun_q;

    // Next state: leave idle when enabled, return to idle only at a symbol boundary.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EIDLE:  if (Tx_En) state_d = S_ACTIVE;
            S_ACTIVE: if (boundary && !Tx_En) state_d = S_EIDLE;
            default:  state_d = S_EIDLE;
        endcase
    end

    // Hold register: a new write wins over the consume that happens on the same edge.
    always_comb begin
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        if (data_write) begin
            hold_d     = Data_in;
            hold_vld_d = 1'b1;
        end else if (load) begin
            hold_vld_d = 1'b0;
        end
    end

    // State, hold and strobe registers.
    always_ff @(posedge Bit_Rate_Clk) begin
        if (!Rst_n) begin
            state_q    <= S_EIDLE;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            strobe_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            strobe_q   <= load;
            underrun_q <= load & ~hold_vld_q;
        end
    end

endmodule

// File: tb/tb_pma_tx_serializer.sv
// tb/tb_pma_tx_serializer.sv - self-checking bench for pma_tx_serializer
module tb_pma_tx_serializer;

    logic       clk = 1'b0;
    logic       Rst_n;
    logic [9:0] Data_in;
    logic       MAC_Data_En;
    logic [9:0] Idle_Sym;
    logic       Tx_En;
    logic       Polarity_Inv;
    logic       Data_Ready, TX_Out_P, TX_Out_N, Sym_Strobe, Underrun;
    logic       m_Data_Ready, m_TX_Out_P, m_TX_Out_N, m_Sym_Strobe, m_Underrun;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pma_tx_serializer #(.DATA_WIDTH(10), .LSB_FIRST(1'b1)) dut (
        .Bit_Rate_Clk (clk),          .Rst_n        (Rst_n),
        .Data_in      (Data_in),      .MAC_Data_En  (MAC_Data_En),
        .Data_Ready   (Data_Ready),   .Idle_Sym     (Idle_Sym),
        .Tx_En        (Tx_En),        .Polarity_Inv (Polarity_Inv),
        .TX_Out_P     (TX_Out_P),     .TX_Out_N     (TX_Out_N),
        .Sym_Strobe   (Sym_Strobe),   .Underrun     (Underrun)
    );

    pma_tx_serializer #(.DATA_WIDTH(10), .LSB_FIRST(1'b0)) dut_msb (
        .Bit_Rate_Clk (clk),          .Rst_n        (Rst_n),
        .Data_in      (Data_in),      .MAC_Data_En  (MAC_Data_En),
        .Data_Ready   (m_Data_Ready), .Idle_Sym     (Idle_Sym),
        .Tx_En        (Tx_En),        .Polarity_Inv (Polarity_Inv),
        .TX_Out_P     (m_TX_Out_P),   .TX_Out_N     (m_TX_Out_N),
        .Sym_Strobe   (m_Sym_Strobe), .Underrun     (m_Underrun)
    );

    typedef struct {
        logic       rstn, en, tx;
        logic [9:0] d;
        logic       rdy, p, n, stb, und;
    } vec_t;

    typedef struct {
        logic [9:0] w;
        logic       idle;
    } sym_t;

    vec_t tbl[16];
    sym_t exp_q[$];
    sym_t cur;
    int   idx = 0;
    bit   mon_en = 1'b0;
    bit   mon_active = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_word(input logic [9:0] w, input bit push, output int stalls);
        bit ok;
        ok = 1'b0;
        stalls = 0;
        MAC_Data_En = 1'b1;
        Data_in = w;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (Data_Ready) begin
                ok = 1'b1;
                if (push) exp_q.push_back('{w, 1'b0});
                break;
            end
            stalls++;
            @(posedge clk);
            #1;
        end
        chk("write_accepted", ok, 1);
        @(posedge clk);
        #1;
        MAC_Data_En = 1'b0;
    endtask

    task automatic wait_strobe(output int n);
        bit ok;
        ok = 1'b0;
        n = 0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            n++;
            if (Sym_Strobe) begin
                ok = 1'b1;
                break;
            end
        end
        chk("strobe_seen", ok, 1);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: each strobe pops the next expected symbol, then its 10 bits are checked in order.
    always @(negedge clk) begin
        logic eb;
        if (!mon_en) begin
            mon_active = 1'b0;
        end else begin
            if (Sym_Strobe) begin
                chk("sym_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    idx = 0;
                    mon_active = 1'b1;
                    chk("sym_underrun", Underrun, cur.idle);
                end
            end else begin
                chk("no_underrun", Underrun, 0);
            end
            if (mon_active) begin
                eb = cur.w[idx] ^ Polarity_Inv;
                chk("sym_bit_p", TX_Out_P, eb);
                chk("sym_bit_n", TX_Out_N, !eb);
                idx++;
                if (idx == 10) mon_active = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [9:0] w;
        int st, n;

        Idle_Sym = 10'h283;
        Polarity_Inv = 1'b0;

        // Reset with a pending write, then one 10'h17C symbol with Tx_En dropped mid-symbol.
        w = 10'h17C;
        for (int i = 0; i < 16; i++) begin
            tbl[i] = '{rstn:1'b1, en:1'b0, tx:1'b0, d:10'h0, rdy:1'b1, p:1'b0, n:1'b0, stb:1'b0, und:1'b0};
            if (i < 3) begin
                tbl[i].rstn = 1'b0; tbl[i].en = 1'b1; tbl[i].d = w; tbl[i].rdy = 1'b0;
            end else if (i == 3) begin
                tbl[i].en = 1'b1; tbl[i].d = w;
            end else if (i == 4) begin
                tbl[i].tx = 1'b1;
            end else if (i < 15) begin
                tbl[i].tx = (i < 8);
                tbl[i].p = w[i-5];
                tbl[i].n = !w[i-5];
                tbl[i].stb = (i == 5);
            end
        end
        for (int i = 0; i < 16; i++) begin
            Rst_n = tbl[i].rstn; MAC_Data_En = tbl[i].en; Tx_En = tbl[i].tx; Data_in = tbl[i].d;
            @(negedge clk);
            chk($sformatf("v%0d_ready", i), Data_Ready, tbl[i].rdy);
            chk($sformatf("v%0d_p", i), TX_Out_P, tbl[i].p);
            chk($sformatf("v%0d_n", i), TX_Out_N, tbl[i].n);
            chk($sformatf("v%0d_strobe", i), Sym_Strobe, tbl[i].stb);
            chk($sformatf("v%0d_underrun", i), Underrun, tbl[i].und);
            @(posedge clk);
            #1;
        end

        mon_en = 1'b1;

        // Underrun: idle symbols repeat until a word arrives, then the word goes out without Underrun.
        repeat (3) exp_q.push_back('{10'h283, 1'b1});
        Tx_En = 1'b1;
        wait_strobe(n);
        wait_strobe(n);
        chk("idle_spacing", n, 10);
        wait_strobe(n);
        write_word(10'h0FF, 1'b1, st);
        wait_strobe(n);
        Tx_En = 1'b0;
        tick(10);
        @(negedge clk);
        chk("t3_drained", exp_q.size(), 0);
        chk("t3_eidle_p", TX_Out_P, 0);
        chk("t3_eidle_n", TX_Out_N, 0);
        tick(1);

        // Back-to-back A, B, C with MAC_Data_En held.
        write_word(10'h155, 1'b1, st);
        MAC_Data_En = 1'b1;
        Data_in = 10'h2AA;
        @(negedge clk);
        chk("b_stall_ready", Data_Ready, 0);
        @(posedge clk);
        #1;
        Tx_En = 1'b1;
        write_word(10'h2AA, 1'b1, st);
        chk("b_accept_on_load", st, 0);
        write_word(10'h0F0, 1'b1, st);
        chk("c_stall_cycles", st, 9);
        wait_strobe(n);
        chk("b_follows_a", n, 1);
        wait_strobe(n);
        chk("c_follows_b", n, 10);
        Tx_En = 1'b0;
        tick(10);
        @(negedge clk);
        chk("t4_drained", exp_q.size(), 0);
        chk("t4_eidle_p", TX_Out_P, 0);
        tick(1);

        // Tx_En dropped at bit 3: symbol completes, then electrical idle.
        write_word(10'h3FF, 1'b1, st);
        Tx_En = 1'b1;
        tick(4);
        Tx_En = 1'b0;
        tick(7);
        @(negedge clk);
        chk("t5_eidle_p", TX_Out_P, 0);
        chk("t5_eidle_n", TX_Out_N, 0);
        chk("t5_drained", exp_q.size(), 0);
        tick(1);

        // MSB-first instance sends Data_in[9] first.
        w = 10'h200;
        write_word(w, 1'b1, st);
        Tx_En = 1'b1;
        tick(1);
        Tx_En = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("msb_p%0d", k), m_TX_Out_P, w[9-k]);
            chk($sformatf("msb_n%0d", k), m_TX_Out_N, !w[9-k]);
            chk($sformatf("msb_strobe%0d", k), m_Sym_Strobe, k == 0);
            tick(1);
        end

        // Polarity inversion swaps the legs.
        Polarity_Inv = 1'b1;
        write_word(10'h001, 1'b1, st);
        Tx_En = 1'b1;
        tick(1);
        Tx_En = 1'b0;
        @(negedge clk);
        chk("pol_p", TX_Out_P, 0);
        chk("pol_n", TX_Out_N, 1);
        tick(10);
        Polarity_Inv = 1'b0;

        // Reset mid-symbol with the hold register full discards the held word.
        write_word(10'h3FF, 1'b1, st);
        Tx_En = 1'b1;
        tick(1);
        write_word(10'h0AA, 1'b0, st);
        tick(4);
        Rst_n = 1'b0;
        mon_en = 1'b0;
        tick(1);
        @(negedge clk);
        chk("rst_p", TX_Out_P, 0);
        chk("rst_n", TX_Out_N, 0);
        chk("rst_strobe", Sym_Strobe, 0);
        chk("rst_ready", Data_Ready, 0);
        @(posedge clk);
        #1;
        exp_q.delete();
        exp_q.push_back('{10'h283, 1'b1});
        Rst_n = 1'b1;
        mon_en = 1'b1;
        tick(1);
        @(negedge clk);
        chk("post_rst_strobe", Sym_Strobe, 1);
        chk("post_rst_underrun", Underrun, 1);
        @(posedge clk);
        #1;
        Tx_En = 1'b0;
        tick(12);
        chk("t6_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
